decode_arbiter: RTL



---
 rtl/decode_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/decode_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 one-hot decoder between NREQ requesters.
// Holds one transaction in flight, captures the decoder result after LAT cycles, and raises a sticky error on a bad decode.
module decode_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_code,
    output logic [NREQ-1:0]   req_ready,
    output logic [2:0]        dec_in,
    input  logic [7:0]        dec_out,
    output logic              rsp_valid,
    output logic [2:0]        rsp_id,
    output logic [7:0]        rsp_data,
    input  logic              rsp_ready,
    output logic              busy,
    output logic [7:0]        grant_cnt,
    output logic              err
);

    // state | meaning
    // IDLE  | arbitrate among valid requesters, capture winner code/id
    // ISSUE | drive captured code to decoder for one cycle
    // WAIT  | hold code for LAT cycles, capture dec_out on the last one
    // RESP  | present response until rsp_ready
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state_q, state_d;
    logic [2:0] rr_ptr_q;
    logic [2:0] dec_in_q;
    logic [2:0] rsp_id_q;
    logic [7:0] rsp_data_q;
    logic [7:0] grant_cnt_q;
    logic       err_q;
    logic [1:0] wait_cnt_q;

    logic [7:0]  valid_ext;
    logic [23:0] code_ext;
    logic [2:0]  codes [8];
    logic [7:0]  ready_ext;
    logic [3:0]  sum;
    logic        win_found;
    logic [2:0]  win_id;

    assign valid_ext = 8'(req_valid);
    assign code_ext  = 24'(req_code);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            codes[i] = code_ext[3*i +: 3];
        end
    end

    // First asserted requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        sum       = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            sum = 4'(rr_ptr_q) + 4'(k);
            if (sum >= 4'(NREQ)) begin
                sum = sum - 4'(NREQ);
            end
            if (!win_found && valid_ext[sum[2:0]]) begin
                win_found = 1'b1;
                win_id    = sum[2:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ready_ext = 8'd0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    ready_ext[win_id] = 1'b1;
                    state_d           = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 3'd0;
            dec_in_q    <= 3'd0;
            rsp_id_q    <= 3'd0;
            rsp_data_q  <= 8'd0;
            grant_cnt_q <= 8'd0;
            err_q       <= 1'b0;
            wait_cnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        dec_in_q <= codes[win_id];
                        rsp_id_q <= win_id;
                    end
                end
                ISSUE: wait_cnt_q <= 2'(LAT - 1);
                WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        rsp_data_q <= dec_out;
                        if (dec_out != (8'b1 << dec_in_q)) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr_q    <= (rsp_id_q == 3'(NREQ - 1)) ? 3'd0 : rsp_id_q + 3'd1;
                        grant_cnt_q <= grant_cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = ready_ext[NREQ-1:0];
    assign dec_in    = dec_in_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);
    assign grant_cnt = grant_cnt_q;
    assign err       = err_q;

endmodule
